// File: rtl/lvp_table.sv
// ---------------------------------------------------------------------------
// lvp_table -- last-value load predictor table
//
// Direct-mapped table indexed by load PC. Each entry holds a partial tag, the
// last committed load value and a saturating confidence counter. Lookups are
// answered one cycle later. At most one used prediction may be outstanding.
// While it is outstanding the block is busy (state WAIT). The prediction
// resolves when the same PC trains, or it is squashed by flush.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   lookup_valid/pc  prediction request from a load in MEM
//   pred_valid       one-cycle response strobe
//   pred_hit         entry valid and tag matched
//   pred_use         hit, confident and nothing outstanding -> may speculate
//   pred_value       stored last value (0 on miss)
//   train_valid/pc/value  resolved load data used to train the table
//   flush            squash the outstanding prediction without training
//   busy             a used prediction is outstanding
//   stat_used        saturating count of responses with pred_use=1
//   stat_correct     saturating count of outstanding predictions found correct
// ---------------------------------------------------------------------------
module lvp_table #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned CONF_BITS   = 2,
  parameter int unsigned CONF_THRESH = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_use,
  output logic [DATA_WIDTH-1:0] pred_value,
  input  logic                  train_valid,
  input  logic [ADDR_WIDTH-1:0] train_pc,
  input  logic [DATA_WIDTH-1:0] train_value,
  input  logic                  flush,
  output logic                  busy,
  output logic [15:0]           stat_used,
  output logic [15:0]           stat_correct
);

  localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [CONF_BITS-1:0] LP_THRESH   = CONF_BITS'(CONF_THRESH);
  localparam logic [CONF_BITS-1:0] LP_CONF_MAX = '1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Table storage. Only the valid bits need reset.
  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_WIDTH-1:0]  r_tag   [ENTRIES];
  logic [DATA_WIDTH-1:0] r_value [ENTRIES];
  logic [CONF_BITS-1:0]  r_conf  [ENTRIES];

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_pred_valid;
  logic                  r_pred_hit;
  logic                  r_pred_use;
  logic [DATA_WIDTH-1:0] r_pred_value;
  logic [ADDR_WIDTH-1:0] r_lookup_pc;   // PC of the response currently shown
  logic [ADDR_WIDTH-1:0] r_out_pc;      // outstanding prediction
  logic [DATA_WIDTH-1:0] r_out_value;
  logic [15:0]           r_stat_used;
  logic [15:0]           r_stat_correct;

  logic [INDEX_WIDTH-1:0] w_lk_idx;
  logic [TAG_WIDTH-1:0]   w_lk_tag;
  logic [INDEX_WIDTH-1:0] w_tr_idx;
  logic [TAG_WIDTH-1:0]   w_tr_tag;
  logic                   w_lk_hit;
  logic                   w_lk_use;
  logic                   w_tr_hit;
  logic                   w_tr_same;
  logic                   w_resolve;
  logic                   w_release;
  logic                   w_enter;
  logic                   w_can_use;

  assign w_lk_idx = lookup_pc[INDEX_WIDTH+1:2];
  assign w_lk_tag = lookup_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign w_tr_idx = train_pc[INDEX_WIDTH+1:2];
  assign w_tr_tag = train_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];

  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_tr_hit  = r_valid[w_tr_idx] && (r_tag[w_tr_idx] == w_tr_tag);
  assign w_tr_same = w_tr_hit && (r_value[w_tr_idx] == train_value);

  // Outstanding prediction resolved by a train of its own PC, or released
  // by flush (flush wins, but the train still updates the table).
  assign w_resolve = (r_state == WAIT) && train_valid && (train_pc == r_out_pc);
  assign w_release = (r_state == WAIT) && (flush || w_resolve);

  // The WAIT transition happens on the edge after the response is shown, so
  // a response with pred_use=1 already on the outputs also blocks new use.
  // A lookup alongside a releasing train/flush sees the block as idle.
  assign w_enter   = (r_state == IDLE) && r_pred_valid && r_pred_use;
  assign w_can_use = ((r_state == IDLE) && !(r_pred_valid && r_pred_use)) || w_release;
  assign w_lk_use  = w_lk_hit && (r_conf[w_lk_idx] >= LP_THRESH) && w_can_use;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_enter)   w_state_next = WAIT;
      WAIT: if (w_release) w_state_next = IDLE;
      default:             w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ lookup response
  // Table arrays are read before this edge's training write lands, giving
  // read-before-write for a lookup and train to the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_hit   <= 1'b0;
      r_pred_use   <= 1'b0;
      r_pred_value <= '0;
      r_lookup_pc  <= '0;
    end else begin
      r_pred_valid <= lookup_valid;
      if (lookup_valid) begin
        r_pred_hit   <= w_lk_hit;
        r_pred_use   <= w_lk_use;
        r_pred_value <= w_lk_hit ? r_value[w_lk_idx] : '0;
        r_lookup_pc  <= lookup_pc;
      end
    end
  end

  // ------------------------------------------- outstanding prediction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_pc    <= '0;
      r_out_value <= '0;
    end else if (w_enter) begin
      r_out_pc    <= r_lookup_pc;
      r_out_value <= r_pred_value;
    end
  end

  // ------------------------------------------------------- statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_used    <= '0;
      r_stat_correct <= '0;
    end else begin
      if (r_pred_valid && r_pred_use && (r_stat_used != 16'hFFFF)) begin
        r_stat_used <= r_stat_used + 16'd1;
      end
      if (w_resolve && !flush && (train_value == r_out_value) &&
          (r_stat_correct != 16'hFFFF)) begin
        r_stat_correct <= r_stat_correct + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------ training
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (train_valid) begin
      r_valid[w_tr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (train_valid) begin
      r_tag[w_tr_idx] <= w_tr_tag;
      if (w_tr_same) begin
        if (r_conf[w_tr_idx] != LP_CONF_MAX) begin
          r_conf[w_tr_idx] <= r_conf[w_tr_idx] + 1'b1;
        end
      end else begin
        r_value[w_tr_idx] <= train_value;
        r_conf[w_tr_idx]  <= '0;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign pred_valid   = r_pred_valid;
  assign pred_hit     = r_pred_hit;
  assign pred_use     = r_pred_use;
  assign pred_value   = r_pred_value;
  assign busy         = (r_state == WAIT);
  assign stat_used    = r_stat_used;
  assign stat_correct = r_stat_correct;

endmodule
